// File: rtl/kmer_signature_streamer.sv
// Rolling k-mer window over a 2-bit nucleotide stream; each complete k-mer is hashed
// and presented with its start index on a single-register valid/ready output.
module kmer_signature_streamer #(
    parameter int          KMER_LEN        = 16,
    parameter int          SIGNATURE_WIDTH = 32,
    parameter int          INDEX_WIDTH     = 10,
    parameter logic [31:0] HASH_MULT       = 32'h9E3779B1,
    parameter logic [31:0] HASH_SEED       = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       nuc_valid,
    output logic                       nuc_ready,
    input  logic [1:0]                 nuc_base,
    input  logic                       nuc_invalid,
    input  logic                       nuc_start,
    input  logic                       nuc_last,
    output logic                       sig_valid,
    input  logic                       sig_ready,
    output logic [SIGNATURE_WIDTH-1:0] sig_value,
    output logic [INDEX_WIDTH-1:0]     sig_index,
    output logic                       sig_last,
    output logic                       seq_empty,
    output logic                       busy
);

    localparam int WIN_W  = 2 * KMER_LEN;
    localparam int FILL_W = $clog2(KMER_LEN + 1);
    localparam logic [FILL_W-1:0]          FILL_FULL = FILL_W'(KMER_LEN);
    localparam logic [FILL_W-1:0]          FILL_ONE  = FILL_W'(1);
    localparam logic [INDEX_WIDTH-1:0]     IDX_OFF   = INDEX_WIDTH'(KMER_LEN - 1);
    localparam logic [INDEX_WIDTH-1:0]     IDX_ONE   = INDEX_WIDTH'(1);
    localparam logic [SIGNATURE_WIDTH-1:0] MULT_C    = SIGNATURE_WIDTH'(HASH_MULT);
    localparam logic [SIGNATURE_WIDTH-1:0] SEED_C    = SIGNATURE_WIDTH'(HASH_SEED);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                     state_r;
    logic [WIN_W-1:0]           window_r;
    logic [FILL_W-1:0]          fill_r;
    logic [INDEX_WIDTH-1:0]     pos_r;
    logic                       emitted_r;
    logic                       sig_valid_r;
    logic [SIGNATURE_WIDTH-1:0] sig_value_r;
    logic [INDEX_WIDTH-1:0]     sig_index_r;
    logic                       sig_last_r;
    logic                       seq_empty_r;
    logic                       busy_r;

    logic                       take_s;
    logic [WIN_W-1:0]           win_base_s;
    logic [WIN_W-1:0]           window_new_s;
    logic [FILL_W-1:0]          fill_base_s;
    logic [FILL_W-1:0]          fill_new_s;
    logic [INDEX_WIDTH-1:0]     pos_base_s;
    logic                       emitted_base_s;
    logic                       emit_s;
    logic [SIGNATURE_WIDTH-1:0] hash_s;
    state_t                     state_nx_s;
    logic                       sig_valid_nx_s;

    assign nuc_ready = !sig_valid_r || sig_ready;
    assign sig_valid = sig_valid_r;
    assign sig_value = sig_value_r;
    assign sig_index = sig_index_r;
    assign sig_last  = sig_last_r;
    assign seq_empty = seq_empty_r;
    assign busy      = busy_r;

    // Per-base update: nuc_start wipes the context before the base itself is applied.
    always_comb begin
        take_s         = nuc_valid && nuc_ready && ((state_r != IDLE) || nuc_start);
        win_base_s     = nuc_start ? '0 : window_r;
        fill_base_s    = nuc_start ? '0 : fill_r;
        pos_base_s     = nuc_start ? '0 : pos_r;
        emitted_base_s = nuc_start ? 1'b0 : emitted_r;
        window_new_s   = (win_base_s << 2) | WIN_W'(nuc_base);
        if (nuc_invalid) begin
            fill_new_s = '0;
        end else if (fill_base_s == FILL_FULL) begin
            fill_new_s = FILL_FULL;
        end else begin
            fill_new_s = fill_base_s + FILL_ONE;
        end
        emit_s = take_s && !nuc_invalid && (fill_new_s == FILL_FULL);
        hash_s = (SIGNATURE_WIDTH'(window_new_s) ^ SEED_C) * MULT_C;
    end

    // Next state and next output-valid, shared by the state register and the busy flag.
    always_comb begin
        if (!take_s) begin
            state_nx_s = state_r;
        end else if (nuc_last) begin
            state_nx_s = IDLE;
        end else if (emit_s) begin
            state_nx_s = STREAM;
        end else begin
            state_nx_s = FILL;
        end
        if (emit_s) begin
            sig_valid_nx_s = 1'b1;
        end else if (sig_ready) begin
            sig_valid_nx_s = 1'b0;
        end else begin
            sig_valid_nx_s = sig_valid_r;
        end
    end

    // State, window context and the single output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            window_r    <= '0;
            fill_r      <= '0;
            pos_r       <= '0;
            emitted_r   <= 1'b0;
            sig_valid_r <= 1'b0;
            sig_value_r <= '0;
            sig_index_r <= '0;
            sig_last_r  <= 1'b0;
            seq_empty_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (take_s) begin
                window_r  <= nuc_invalid ? win_base_s : window_new_s;
                fill_r    <= fill_new_s;
                pos_r     <= pos_base_s + IDX_ONE;
                emitted_r <= emitted_base_s || emit_s;
            end
            if (emit_s) begin
                sig_value_r <= hash_s;
                sig_index_r <= pos_base_s - IDX_OFF;
                sig_last_r  <= nuc_last;
            end
            state_r     <= state_nx_s;
            sig_valid_r <= sig_valid_nx_s;
            // Empty marker only when the whole sequence ends without a single k-mer.
            seq_empty_r <= take_s && nuc_last && !emit_s && !emitted_base_s;
            busy_r      <= (state_nx_s != IDLE) || sig_valid_nx_s;
        end
    end

endmodule

// File: tb/tb_kmer_signature_streamer.sv
// Scoreboard bench: two instances (K=4 with identity hash, default K=16) share one
// accepted base stream; a sequence-level model predicts signatures and empty markers.
module tb_kmer_signature_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        nuc_valid, nuc_invalid, nuc_start, nuc_last, sig_ready;
    logic [1:0]  nuc_base;
    logic        nuc_ready_a, sig_valid_a, sig_last_a, seq_empty_a, busy_a;
    logic [31:0] sig_value_a;
    logic [9:0]  sig_index_a;
    logic        nuc_valid_b, nuc_ready_b, sig_valid_b, sig_last_b, seq_empty_b, busy_b;
    logic        sig_ready_b;
    logic [31:0] sig_value_b;
    logic [9:0]  sig_index_b;

    typedef struct {
        logic [31:0] val;
        logic [9:0]  idx;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   ea[$];
    int   eb[$];
    int   hist[$];
    bit   in_seq;
    int   pos;
    bit   emitted[2];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;
    int   ready_mode = 0;
    bit   held;

    always #5 clk = ~clk;
    assign nuc_valid_b = nuc_valid && nuc_ready_a;
    assign sig_ready_b = 1'b1;

    kmer_signature_streamer #(.KMER_LEN(4), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10),
                              .HASH_MULT(32'd1), .HASH_SEED(32'd0)) dut_a (
        .clk(clk), .reset(reset), .nuc_valid(nuc_valid), .nuc_ready(nuc_ready_a),
        .nuc_base(nuc_base), .nuc_invalid(nuc_invalid), .nuc_start(nuc_start),
        .nuc_last(nuc_last), .sig_valid(sig_valid_a), .sig_ready(sig_ready),
        .sig_value(sig_value_a), .sig_index(sig_index_a), .sig_last(sig_last_a),
        .seq_empty(seq_empty_a), .busy(busy_a));

    kmer_signature_streamer dut_b (
        .clk(clk), .reset(reset), .nuc_valid(nuc_valid_b), .nuc_ready(nuc_ready_b),
        .nuc_base(nuc_base), .nuc_invalid(nuc_invalid), .nuc_start(nuc_start),
        .nuc_last(nuc_last), .sig_valid(sig_valid_b), .sig_ready(sig_ready_b),
        .sig_value(sig_value_b), .sig_index(sig_index_b), .sig_last(sig_last_b),
        .seq_empty(seq_empty_b), .busy(busy_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit kmer_ok(input int k);
        if (hist.size() < k) return 1'b0;
        for (int i = 0; i < k; i++)
            if (hist[hist.size() - 1 - i] < 0) return 1'b0;
        return 1'b1;
    endfunction

    // Base-4 number of the last k bases, first base most significant, times the multiplier.
    function automatic logic [31:0] kmer_hash(input int k, input logic [63:0] mult);
        logic [63:0] v;
        logic [63:0] p;
        v = 64'd0;
        for (int i = k - 1; i >= 0; i--)
            v = v * 64'd4 + 64'(hist[hist.size() - 1 - i]);
        p = v * mult;
        return p[31:0];
    endfunction

    task automatic model_base(input bit s, input bit l, input bit inv, input int b);
        int  k;
        bit  emit;
        exp_t e;
        if (s) begin
            in_seq = 1'b1;
            hist.delete();
            pos = 0;
            emitted[0] = 1'b0;
            emitted[1] = 1'b0;
        end
        if (!in_seq) return;
        hist.push_back(inv ? -1 : b);
        if (hist.size() > 16) void'(hist.pop_front());
        for (int d = 0; d < 2; d++) begin
            k = (d == 0) ? 4 : 16;
            emit = kmer_ok(k);
            if (emit) begin
                e.val  = kmer_hash(k, (d == 0) ? 64'd1 : 64'h9E3779B1);
                e.idx  = 10'((pos - (k - 1)) & 1023);
                e.last = l;
                e.cyc  = cyc;
                if (d == 0) qa.push_back(e);
                else        qb.push_back(e);
                emitted[d] = 1'b1;
            end else if (l && !emitted[d]) begin
                if (d == 0) ea.push_back(cyc);
                else        eb.push_back(cyc);
            end
        end
        pos++;
        if (l) in_seq = 1'b0;
    endtask

    task automatic send(input bit s, input bit l, input bit inv, input int b);
        bit acc;
        acc = 1'b0;
        nuc_valid = 1'b1;
        nuc_start = s;
        nuc_last = l;
        nuc_invalid = inv;
        nuc_base = 2'(b);
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = nuc_ready_a;
            @(posedge clk);
            #1;
        end
        if (acc) model_base(s, l, inv, b);
        else check("base_accept_timeout", 64'd0, 64'd1);
        nuc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        nuc_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       sig_ready = 1'b1;
            1:       sig_ready = ($urandom_range(0, 3) != 0);
            default: sig_ready = 1'b0;
        endcase
    end

    // Monitor for the K=4 instance: backpressure-aware, checks stability while held.
    always @(negedge clk) begin
        if (reset) begin
            held <= 1'b0;
        end else begin
            check("a_nuc_ready", nuc_ready_a, !sig_valid_a || sig_ready);
            check("a_busy", busy_a, in_seq || sig_valid_a);
            if (sig_valid_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_sig", 64'd1, 64'd0);
                end else begin
                    check("a_sig_value", sig_value_a, qa[0].val);
                    check("a_sig_index", sig_index_a, qa[0].idx);
                    check("a_sig_last", sig_last_a, qa[0].last);
                    if (!held) check("a_sig_latency", 64'(cyc), 64'(qa[0].cyc));
                    if (sig_ready) void'(qa.pop_front());
                end
            end
            held <= sig_valid_a && !sig_ready;
            if (seq_empty_a) begin
                if (ea.size() == 0) check("a_unexpected_empty", 64'd1, 64'd0);
                else check("a_seq_empty_cycle", 64'(cyc), 64'(ea.pop_front()));
            end
        end
    end

    // Monitor for the default-parameter instance, always ready.
    always @(negedge clk) begin
        if (!reset) begin
            check("b_nuc_ready", nuc_ready_b, 1'b1);
            if (sig_valid_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_sig", 64'd1, 64'd0);
                end else begin
                    check("b_sig_value", sig_value_b, qb[0].val);
                    check("b_sig_index", sig_index_b, qb[0].idx);
                    check("b_sig_last", sig_last_b, qb[0].last);
                    check("b_sig_latency", 64'(cyc), 64'(qb[0].cyc));
                    void'(qb.pop_front());
                end
            end
            if (seq_empty_b) begin
                if (eb.size() == 0) check("b_unexpected_empty", 64'd1, 64'd0);
                else check("b_seq_empty_cycle", 64'(cyc), 64'(eb.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1;
        nuc_valid = 1'b0;
        nuc_start = 1'b0;
        nuc_last = 1'b0;
        nuc_invalid = 1'b0;
        nuc_base = 2'd0;
        sig_ready = 1'b1;
        in_seq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sig_valid", sig_valid_a, 1'b0);
        check("reset_sig_value", sig_value_a, 32'd0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_seq_empty", seq_empty_a, 1'b0);
        check("reset_nuc_ready", nuc_ready_a, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Basic stream A,C,G,T,A
        send(1, 0, 0, 0); send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 0, 0, 3); send(0, 1, 0, 0);
        idle(3);
        // N in the middle: A,C,G,T,N,C,G,T,A
        send(1, 0, 0, 0); send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 0, 0, 3); send(0, 0, 1, 0);
        send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 0, 0, 3); send(0, 1, 0, 0);
        idle(3);
        // Short sequence and a one-base sequence
        send(1, 0, 0, 0); send(0, 1, 0, 1);
        idle(3);
        send(1, 1, 0, 2);
        idle(3);
        // Backpressure on the basic stream, released after a while
        ready_mode = 2;
        fork
            begin
                send(1, 0, 0, 0); send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 0, 0, 3); send(0, 1, 0, 0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        idle(4);
        // Restart mid-sequence
        send(1, 0, 0, 0); send(0, 0, 0, 1); send(1, 0, 0, 2); send(0, 0, 0, 3);
        send(0, 0, 0, 0); send(0, 1, 0, 1);
        idle(3);
        // Reset while a signature is pending, then a start-less base
        ready_mode = 2;
        send(1, 0, 0, 0); send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 0, 0, 3);
        check("pre_reset_sig_valid", sig_valid_a, 1'b1);
        reset = 1'b1;
        #1;
        check("async_reset_sig_valid", sig_valid_a, 1'b0);
        check("async_reset_busy", busy_a, 1'b0);
        qa.delete(); qb.delete(); ea.delete(); eb.delete(); hist.delete();
        in_seq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 0;
        idle(1);
        send(0, 0, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3);
        idle(3);
        // Sixteen T's: default hash on the K=16 instance
        for (int i = 0; i < 16; i++) send(i == 0, i == 15, 0, 3);
        idle(3);
        // Randomized traffic with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 600; i++) begin
            send($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) idle(1);
        end
        ready_mode = 0;
        idle(20);
        check("a_sig_queue_drained", 64'(qa.size()), 64'd0);
        check("b_sig_queue_drained", 64'(qb.size()), 64'd0);
        check("a_empty_queue_drained", 64'(ea.size()), 64'd0);
        check("b_empty_queue_drained", 64'(eb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
